// File: rtl/ldpc_shuffler.sv
// rtl/ldpc_shuffler.sv - three-stage pipelined cyclic LLR rotator between VN and CN arrays
module ldpc_shuffler #(
  parameter int FOLDFACTOR     = 4,
  parameter int NUMINSTANCES   = 90,
  parameter int LOG2INSTANCES  = 7,
  parameter int LLRWIDTH       = 4,
  parameter int LASTSHIFTWIDTH = 2,
  parameter int LASTSHIFTDIST  = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             first_half,
  input  logic [1:0]                       shift0,
  input  logic [2:0]                       shift1,
  input  logic [LASTSHIFTWIDTH-1:0]        shift2,
  input  logic [NUMINSTANCES*LLRWIDTH-1:0] vn_concat,
  input  logic [NUMINSTANCES*LLRWIDTH-1:0] cn_concat,
  output logic [NUMINSTANCES*LLRWIDTH-1:0] sh_concat
);

  localparam int NW  = NUMINSTANCES * LLRWIDTH;
  localparam int SF0 = (FOLDFACTOR == 1) ? 90 : (FOLDFACTOR == 2) ? 45 : (FOLDFACTOR == 3) ? 30 : 23;
  localparam int SF1 = (FOLDFACTOR == 1) ? 12 : (FOLDFACTOR == 2) ? 6  : (FOLDFACTOR == 3) ? 4  : 3;
  localparam int DW  = LOG2INSTANCES + 1;

  typedef logic [DW-1:0] dist_t;

  // Rotate forward by d lanes (out[j] = v[j-d]); inverse uses N-d. Indexing a doubled
  // copy keeps every wrap modulo N rather than modulo a power of two.
  function automatic logic [NW-1:0] rotate(input logic [NW-1:0] v, input dist_t d, input logic fwd);
    int e;
    e = int'(d) % NUMINSTANCES;
    if (!fwd && e != 0) e = NUMINSTANCES - e;
    return NW'({v, v} >> ((NUMINSTANCES - e) * LLRWIDTH));
  endfunction

  logic [NW-1:0] s0_data, s1_data;
  logic          s0_fh, s1_fh;
  logic [NW-1:0] s0_next, s1_next, s2_next;
  dist_t         d0, d1, d2;

  always_comb begin
    d0 = dist_t'(int'(shift0) * SF0);
    d1 = dist_t'(int'(shift1) * SF1);
    // shift2 beyond its legal maximum has no defined result; saturate it
    d2 = dist_t'((int'(shift2) > LASTSHIFTDIST) ? LASTSHIFTDIST : int'(shift2));
    s0_next = rotate(first_half ? vn_concat : cn_concat, d0, first_half);
    s1_next = rotate(s0_data, d1, s0_fh);
    s2_next = rotate(s1_data, d2, s1_fh);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_data   <= '0;
      s1_data   <= '0;
      sh_concat <= '0;
      s0_fh     <= 1'b1;
      s1_fh     <= 1'b1;
    end else begin
      s0_data   <= s0_next;
      s0_fh     <= first_half;
      s1_data   <= s1_next;
      s1_fh     <= s0_fh;
      sh_concat <= s2_next;
    end
  end

endmodule

// File: tb/tb_ldpc_shuffler.sv
// tb/tb_ldpc_shuffler.sv - randomized and directed checks of ldpc_shuffler against a lane-level model
module tb_ldpc_shuffler;

  localparam int N  = 90;
  localparam int W  = 4;
  localparam int NW = N * W;
  localparam int SF0 = 23;
  localparam int SF1 = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          first_half;
  logic [1:0]    shift0;
  logic [2:0]    shift1;
  logic [1:0]    shift2;
  logic [NW-1:0] vn_concat, cn_concat, sh_concat;

  int tests = 0;
  int fails = 0;

  logic [NW-1:0] exp_q[$];
  logic [2:0]    p1_s1;
  logic [1:0]    p1_s2, p2_s2;
  logic [NW-1:0] pattern;

  ldpc_shuffler dut (
    .clk(clk), .rst(rst), .first_half(first_half),
    .shift0(shift0), .shift1(shift1), .shift2(shift2),
    .vn_concat(vn_concat), .cn_concat(cn_concat), .sh_concat(sh_concat)
  );

  always #5 clk = ~clk;

  function automatic logic [NW-1:0] model(input logic [NW-1:0] vin, input int s, input logic fwd);
    logic [NW-1:0] r;
    int dst;
    r = '0;
    for (int i = 0; i < N; i++) begin
      dst = fwd ? (i + s) % N : (i - s + N) % N;
      r[dst*W +: W] = vin[i*W +: W];
    end
    return r;
  endfunction

  function automatic logic [NW-1:0] rand_vec();
    logic [NW-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'($urandom);
    return r;
  endfunction

  function automatic logic [W-1:0] lane(input logic [NW-1:0] v, input int j);
    return v[j*W +: W];
  endfunction

  // Called at a negedge: drives one vector with its staggered shifts, checks the vector two edges older.
  task automatic step(input logic [NW-1:0] vn, input logic [NW-1:0] cn, input logic fh, input int s);
    logic [NW-1:0] exp_v;
    first_half = fh;
    vn_concat  = vn;
    cn_concat  = cn;
    shift0     = 2'(s / SF0);
    shift1     = p1_s1;
    shift2     = p2_s2;
    p2_s2      = p1_s2;
    p1_s1      = 3'((s % SF0) / SF1);
    p1_s2      = 2'((s % SF0) % SF1);
    exp_q.push_back(model(fh ? vn : cn, s, fh));
    @(posedge clk);
    #1;
    if (exp_q.size() == 3) begin
      exp_v = exp_q.pop_front();
      tests++;
      assert (sh_concat === exp_v)
        else begin fails++; $error("FAIL pipeline s=%0d fh=%0b got=%h exp=%h", s, fh, sh_concat, exp_v); end
    end
    @(negedge clk);
  endtask

  task automatic directed(input logic fh, input int s, input int j0, input logic [W-1:0] e0,
                          input int j1, input logic [W-1:0] e1);
    for (int k = 0; k < 3; k++) step(pattern, pattern, fh, s);
    tests++;
    assert (lane(sh_concat, j0) === e0)
      else begin fails++; $error("FAIL spot s=%0d lane%0d got=%0d exp=%0d", s, j0, lane(sh_concat, j0), e0); end
    tests++;
    assert (lane(sh_concat, j1) === e1)
      else begin fails++; $error("FAIL spot s=%0d lane%0d got=%0d exp=%0d", s, j1, lane(sh_concat, j1), e1); end
  endtask

  initial begin
    int s_list[9];
    s_list = '{10, 11, 12, 21, 22, 23, 44, 45, 46};
    for (int j = 0; j < N; j++) pattern[j*W +: W] = W'(j % 16);
    rst = 1'b1; first_half = 1'b1; shift0 = '0; shift1 = '0; shift2 = '0;
    vn_concat = '0; cn_concat = '0;
    p1_s1 = '0; p1_s2 = '0; p2_s2 = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    assert (sh_concat === '0)
      else begin fails++; $error("FAIL reset_state got=%h exp=0", sh_concat); end
    @(negedge clk);
    rst = 1'b0;

    directed(1'b1, 89, 0, 4'd1, 89, 4'd0);
    directed(1'b1, 0, 0, 4'd0, 5, 4'd5);
    directed(1'b1, 1, 1, 4'd0, 0, 4'd9);
    directed(1'b1, 45, 45, 4'd0, 0, 4'd13);
    directed(1'b0, 1, 0, 4'd1, 89, 4'd0);
    foreach (s_list[k]) step(pattern, pattern, 1'b1, s_list[k]);

    for (int t = 0; t < 1500; t++)
      step(rand_vec(), rand_vec(), 1'($urandom), int'($urandom_range(0, N - 1)));

    #2;
    rst = 1'b1;
    #1;
    tests++;
    assert (sh_concat === '0)
      else begin fails++; $error("FAIL async_reset got=%h exp=0", sh_concat); end
    @(posedge clk);
    #1;
    tests++;
    assert (sh_concat === '0)
      else begin fails++; $error("FAIL reset_hold got=%h exp=0", sh_concat); end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    p1_s1 = '0; p1_s2 = '0; p2_s2 = '0;

    for (int t = 0; t < 1500; t++)
      step(rand_vec(), rand_vec(), 1'($urandom), int'($urandom_range(0, N - 1)));
    for (int t = 0; t < 2; t++) step(pattern, pattern, 1'b1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
